// File: rtl/wb_stage.sv
// Writeback stage: registers M-stage control/data, aligns BRAM load data, drives the RF write port.
// Optional retired-instruction counter built only when WB_INSTRET_EN is defined.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_m,
  input  logic            reg_we_m,
  input  logic [1:0]      wb_sel_m,
  input  logic [4:0]      rd_m,
  input  logic [2:0]      funct3_m,
  input  logic [XLEN-1:0] alu_m,
  input  logic [XLEN-1:0] pc_m,
  input  logic [XLEN-1:0] dmem_dout,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [63:0]     instret
);

  logic            valid_w;
  logic            reg_we_w;
  logic [1:0]      wb_sel_w;
  logic [4:0]      rd_w;
  logic [2:0]      funct3_w;
  logic [XLEN-1:0] alu_w;
  logic [XLEN-1:0] pcp4_w;

  // Flush only needs to kill valid; the payload fields are don't-care, so they load normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_w  <= 1'b0;
      reg_we_w <= 1'b0;
      wb_sel_w <= 2'd0;
      rd_w     <= 5'd0;
      funct3_w <= 3'd0;
      alu_w    <= '0;
      pcp4_w   <= '0;
    end else if (flush || !stall) begin
      valid_w  <= flush ? 1'b0 : valid_m;
      reg_we_w <= reg_we_m;
      wb_sel_w <= wb_sel_m;
      rd_w     <= rd_m;
      funct3_w <= funct3_m;
      alu_w    <= alu_m;
      pcp4_w   <= pc_m + XLEN'(4);
    end
  end

  logic [1:0]      off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;

  assign off = alu_w[1:0];

  // Misaligned halfwords just use off[1]; no trap path exists here.
  always_comb begin
    load_byte = 8'd0;
    load_half = 16'd0;
    load_data = dmem_dout;
    case (off)
      2'd0:    load_byte = dmem_dout[7:0];
      2'd1:    load_byte = dmem_dout[15:8];
      2'd2:    load_byte = dmem_dout[23:16];
      default: load_byte = dmem_dout[31:24];
    endcase
    load_half = off[1] ? dmem_dout[31:16] : dmem_dout[15:0];
    case (funct3_w)
      3'd0:    load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'd4:    load_data = {{(XLEN-8){1'b0}}, load_byte};
      3'd1:    load_data = {{(XLEN-16){load_half[15]}}, load_half};
      3'd5:    load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = dmem_dout;
    endcase
  end

  always_comb begin
    rf_wd = '0;
    case (wb_sel_w)
      2'd0:    rf_wd = alu_w;
      2'd1:    rf_wd = load_data;
      2'd2:    rf_wd = pcp4_w;
      default: rf_wd = '0;
    endcase
  end

  assign rf_we = valid_w & reg_we_w & (rd_w != 5'd0);
  assign rf_wa = rd_w;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // A stalled instruction retires only in the cycle it leaves W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
    end else if (valid_w && !stall) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected RF-port values queued at drive time, checked one edge later.
// Also tracks an independent retirement model for instret (zero unless WB_INSTRET_EN).
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        valid_m;
  logic        reg_we_m;
  logic [1:0]  wb_sel_m;
  logic [4:0]  rd_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_m;
  logic [31:0] pc_m;
  logic [31:0] dmem_dout;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [63:0] instret;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_m(valid_m), .reg_we_m(reg_we_m), .wb_sel_m(wb_sel_m), .rd_m(rd_m),
    .funct3_m(funct3_m), .alu_m(alu_m), .pc_m(pc_m), .dmem_dout(dmem_dout),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .instret(instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [37:0] FULL    = '1;
  localparam logic [37:0] WE_ONLY = 38'h20_0000_0000;

  logic [37:0] exp_q[$];
  logic [37:0] msk_q[$];
  int          vectors;
  int          fails;
  logic        m_valid_w;
  logic [63:0] exp_instret;

  function automatic logic [37:0] pk(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    return {we, wa, wd};
  endfunction

  task automatic check_rf(input string tag, input logic [37:0] exp, input logic [37:0] msk);
    logic [37:0] obs;
    obs = {rf_we, rf_wa, rf_wd};
    vectors++;
    assert ((obs & msk) === (exp & msk)) else begin
      fails++;
      $error("FAIL %s rf observed=%h expected=%h mask=%h", tag, obs, exp, msk);
    end
  endtask

  task automatic check_instret(input string tag);
    vectors++;
    assert (instret === exp_instret) else begin
      fails++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_instret);
    end
  endtask

  // scoreboard pop: compare the oldest queued expectation with the RF port
  task automatic sb_check(input string tag);
    logic [37:0] e;
    logic [37:0] m;
    if (exp_q.size() == 0) begin
      vectors++;
      fails++;
      $error("FAIL %s scoreboard empty observed=%h expected=none", tag, {rf_we, rf_wa, rf_wd});
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      check_rf(tag, e, m);
    end
    check_instret(tag);
  endtask

  // driver: apply M-stage inputs, queue expectation, clock once, check
  task automatic step(input string tag, input logic st, input logic fl, input logic v,
                      input logic we, input logic [1:0] sel, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                      input logic [37:0] exp, input logic [37:0] msk);
    stall    = st;
    flush    = fl;
    valid_m  = v;
    reg_we_m = we;
    wb_sel_m = sel;
    rd_m     = rd;
    funct3_m = f3;
    alu_m    = alu;
    pc_m     = pc;
    exp_q.push_back(exp);
    msk_q.push_back(msk);
    @(posedge clk);
`ifdef WB_INSTRET_EN
    if (m_valid_w && !st) exp_instret = exp_instret + 64'd1;
`endif
    if (fl) m_valid_w = 1'b0;
    else if (!st) m_valid_w = v;
    #1;
    sb_check(tag);
  endtask

  initial begin
    vectors     = 0;
    fails       = 0;
    m_valid_w   = 1'b0;
    exp_instret = 64'd0;
    rst_n       = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    valid_m     = 1'b1;
    reg_we_m    = 1'b1;
    wb_sel_m    = 2'd0;
    rd_m        = 5'd9;
    funct3_m    = 3'd0;
    alu_m       = 32'hDEAD_BEEF;
    pc_m        = 32'h100;
    dmem_dout   = 32'h80F1_7F01;

    #12;
    check_rf("reset_state", pk(1'b0, 5'd0, 32'd0), FULL);
    check_instret("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU and PC+4 paths
    step("alu",       0, 0, 1, 1, 2'd0, 5'd5, 3'd2, 32'h1234, 32'h200, pk(1, 5'd5, 32'h1234), FULL);
    step("pc4_wrap",  0, 0, 1, 1, 2'd2, 5'd6, 3'd2, 32'h0, 32'hFFFF_FFFC, pk(1, 5'd6, 32'h0), FULL);
    step("pc4",       0, 0, 1, 1, 2'd2, 5'd7, 3'd2, 32'h0, 32'h0000_1000, pk(1, 5'd7, 32'h1004), FULL);
    step("sel3",      0, 0, 1, 1, 2'd3, 5'd8, 3'd2, 32'h55, 32'h0, pk(1, 5'd8, 32'h0), FULL);

    // loads against dmem_dout = 0x80F17F01
    step("lb_off3",   0, 0, 1, 1, 2'd1, 5'd10, 3'd0, 32'h1003, 32'h0, pk(1, 5'd10, 32'hFFFF_FF80), FULL);
    step("lbu_off1",  0, 0, 1, 1, 2'd1, 5'd11, 3'd4, 32'h1001, 32'h0, pk(1, 5'd11, 32'h0000_007F), FULL);
    step("lb_off0",   0, 0, 1, 1, 2'd1, 5'd11, 3'd0, 32'h1000, 32'h0, pk(1, 5'd11, 32'h0000_0001), FULL);
    step("lh_off2",   0, 0, 1, 1, 2'd1, 5'd12, 3'd1, 32'h1002, 32'h0, pk(1, 5'd12, 32'hFFFF_80F1), FULL);
    step("lhu_off0",  0, 0, 1, 1, 2'd1, 5'd13, 3'd5, 32'h1000, 32'h0, pk(1, 5'd13, 32'h0000_7F01), FULL);
    step("lh_mis3",   0, 0, 1, 1, 2'd1, 5'd13, 3'd1, 32'h1003, 32'h0, pk(1, 5'd13, 32'hFFFF_80F1), FULL);
    step("lw",        0, 0, 1, 1, 2'd1, 5'd14, 3'd2, 32'h1002, 32'h0, pk(1, 5'd14, 32'h80F1_7F01), FULL);

    // x0 suppression, no-write and invalid instructions
    step("x0",        0, 0, 1, 1, 2'd0, 5'd0, 3'd2, 32'h77, 32'h0, pk(0, 5'd0, 32'h77), FULL);
    step("no_we",     0, 0, 1, 0, 2'd0, 5'd3, 3'd2, 32'h78, 32'h0, pk(0, 5'd3, 32'h78), FULL);
    step("invalid",   0, 0, 0, 1, 2'd0, 5'd3, 3'd2, 32'h79, 32'h0, pk(0, 5'd3, 32'h79), FULL);

    // stall holds W for 3 cycles; retirement counted once on exit
    step("st_enter",  0, 0, 1, 1, 2'd0, 5'd7, 3'd2, 32'h55, 32'h0, pk(1, 5'd7, 32'h55), FULL);
    for (int i = 0; i < 3; i++)
      step("st_hold", 1, 0, 1, 1, 2'd2, 5'd9, 3'd0, 32'hAAAA, 32'h40, pk(1, 5'd7, 32'h55), FULL);
    step("st_exit",   0, 0, 0, 0, 2'd0, 5'd0, 3'd2, 32'h0, 32'h0, pk(0, 5'd0, 32'h0), FULL);

    // plain flush, then stall+flush together (flush wins, no retirement)
    step("fl_pre",    0, 0, 1, 1, 2'd0, 5'd4, 3'd2, 32'h44, 32'h0, pk(1, 5'd4, 32'h44), FULL);
    step("flush",     0, 1, 1, 1, 2'd0, 5'd3, 3'd2, 32'h66, 32'h0, pk(0, 5'd0, 32'h0), WE_ONLY);
    step("sf_pre",    0, 0, 1, 1, 2'd0, 5'd4, 3'd2, 32'h45, 32'h0, pk(1, 5'd4, 32'h45), FULL);
    step("st_flush",  1, 1, 1, 1, 2'd0, 5'd3, 3'd2, 32'h67, 32'h0, pk(0, 5'd0, 32'h0), WE_ONLY);
    step("sf_post",   0, 0, 1, 1, 2'd0, 5'd2, 3'd2, 32'h68, 32'h0, pk(1, 5'd2, 32'h68), FULL);

`ifdef WB_INSTRET_EN
    // counter wrap: preload all-ones while an instruction sits in W
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    step("wrap",      0, 0, 0, 0, 2'd0, 5'd0, 3'd2, 32'h0, 32'h0, pk(0, 5'd0, 32'h0), FULL);
`endif

    // asynchronous reset mid-cycle while a writing instruction is in W
    step("rst_pre",   0, 0, 1, 1, 2'd0, 5'd15, 3'd2, 32'hCAFE, 32'h0, pk(1, 5'd15, 32'hCAFE), FULL);
    #2;
    rst_n = 1'b0;
    m_valid_w   = 1'b0;
    exp_instret = 64'd0;
    #1;
    check_rf("rst_async", pk(0, 5'd0, 32'd0), FULL);
    check_instret("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_rel",   0, 0, 1, 1, 2'd0, 5'd16, 3'd2, 32'hBEEF, 32'h0, pk(1, 5'd16, 32'hBEEF), FULL);
    step("drain",     0, 0, 0, 0, 2'd0, 5'd0, 3'd2, 32'h0, 32'h0, pk(0, 5'd0, 32'h0), FULL);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
